// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: FSM encoding, accumulator width, symbol/sign mapping,
// carrier lookup and the transmit mapping used by the matching modulator.
package qpsk_pkg;

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned PROD_W = 18;
  localparam int          AMP    = 16000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INTEGRATE = 2'd1,
    ST_DUMP      = 2'd2
  } state_t;

  typedef struct packed {
    logic i_neg;
    logic q_neg;
  } iq_sign_t;

  // Gray-style constellation: 00=(+,+) 01=(-,+) 10=(-,-) 11=(+,-)
  function automatic iq_sign_t sym_to_sign(input logic [1:0] sym);
    iq_sign_t s;
    case (sym)
      2'b00:   s = '{i_neg: 1'b0, q_neg: 1'b0};
      2'b01:   s = '{i_neg: 1'b1, q_neg: 1'b0};
      2'b10:   s = '{i_neg: 1'b1, q_neg: 1'b1};
      default: s = '{i_neg: 1'b0, q_neg: 1'b1};
    endcase
    return s;
  endfunction

  function automatic logic [1:0] sign_to_sym(input logic i_neg, input logic q_neg);
    logic [1:0] sym;
    case ({i_neg, q_neg})
      2'b00:   sym = 2'b00;
      2'b10:   sym = 2'b01;
      2'b11:   sym = 2'b10;
      default: sym = 2'b11;
    endcase
    return sym;
  endfunction

  // First quadrant of a 64-point sine, index 0..16, full scale 32767.
  function automatic logic signed [15:0] sin_quarter(input logic [4:0] k);
    logic signed [15:0] v;
    case (k)
      5'd0:    v = 16'sd0;
      5'd1:    v = 16'sd3212;
      5'd2:    v = 16'sd6393;
      5'd3:    v = 16'sd9512;
      5'd4:    v = 16'sd12539;
      5'd5:    v = 16'sd15446;
      5'd6:    v = 16'sd18204;
      5'd7:    v = 16'sd20787;
      5'd8:    v = 16'sd23170;
      5'd9:    v = 16'sd25329;
      5'd10:   v = 16'sd27245;
      5'd11:   v = 16'sd28898;
      5'd12:   v = 16'sd30273;
      5'd13:   v = 16'sd31356;
      5'd14:   v = 16'sd32137;
      5'd15:   v = 16'sd32609;
      default: v = 16'sd32767;
    endcase
    return v;
  endfunction

  function automatic logic signed [15:0] sin_lut(input logic [5:0] idx);
    logic signed [15:0] v;
    case (idx[5:4])
      2'd0:    v =  sin_quarter({1'b0, idx[3:0]});
      2'd1:    v =  sin_quarter(5'd16 - {1'b0, idx[3:0]});
      2'd2:    v = -sin_quarter({1'b0, idx[3:0]});
      default: v = -sin_quarter(5'd16 - {1'b0, idx[3:0]});
    endcase
    return v;
  endfunction

  // s = I*cos - Q*sin, so the demodulator's -sin mixer recovers +Q.
  function automatic logic signed [15:0] mod_sample(input logic [1:0]         sym,
                                                     input logic signed [15:0] s,
                                                     input logic signed [15:0] c);
    iq_sign_t           sg;
    logic signed [31:0] ic;
    logic signed [31:0] qs;
    sg = sym_to_sign(sym);
    ic = 32'(c) * AMP;
    qs = 32'(s) * AMP;
    if (sg.i_neg) ic = -ic;
    if (sg.q_neg) qs = -qs;
    return 16'((ic - qs) >>> 15);
  endfunction

endpackage

// File: rtl/qpsk_demodulator_if.sv
// Demodulator stream bundle: carrier control and samples in, decisions out.
interface qpsk_demodulator_if;
  logic [31:0]        fcw;
  logic signed [15:0] rx_sample;
  logic               sym_sync;
  logic [1:0]         symbol_out;
  logic               symbol_valid;

  modport master (output fcw, rx_sample, sym_sync, input  symbol_out, symbol_valid);
  modport slave  (input  fcw, rx_sample, sym_sync, output symbol_out, symbol_valid);
endinterface

// File: rtl/qpsk_demodulator_dds.sv
// Phase-accumulator DDS; sin/cos follow the registered phase combinationally.
module dds
  import qpsk_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        fcw,
  output logic signed [15:0] data_sin,
  output logic signed [15:0] data_cos
);

  logic [31:0] r_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_phase <= '0;
    else        r_phase <= r_phase + fcw;
  end

  always_comb begin
    data_sin = sin_lut(r_phase[31:26]);
    data_cos = sin_lut(r_phase[31:26] + 6'd16);
  end

endmodule

// File: rtl/qpsk_demodulator.sv
// QPSK integrate-and-dump demodulator. Defining QPSK_DEMOD_DEBUG_EN adds
// i_acc_out/q_acc_out carrying the accumulators latched at each decision.
module qpsk_demodulator
  import qpsk_pkg::*;
#(
  parameter int SYSTEM_CLK_FREQ = 100_000_000,
  parameter int SYMBOL_RATE     = 1_000_000,
  parameter int SYMBOL_PERIOD   = SYSTEM_CLK_FREQ / SYMBOL_RATE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        fcw,
  input  logic signed [15:0] rx_sample,
  input  logic               sym_sync,
  output logic [1:0]         symbol_out,
  output logic               symbol_valid
`ifdef QPSK_DEMOD_DEBUG_EN
  ,
  output logic signed [ACC_W-1:0] i_acc_out,
  output logic signed [ACC_W-1:0] q_acc_out
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(SYMBOL_PERIOD - 1);

  logic signed [15:0]       w_sin;
  logic signed [15:0]       w_cos;
  logic signed [PROD_W-1:0] r_i_prod;
  logic signed [PROD_W-1:0] r_q_prod;
  logic signed [ACC_W-1:0]  r_i_acc;
  logic signed [ACC_W-1:0]  r_q_acc;
  logic [7:0]               r_symbol_cnt;
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_load;
  logic                     w_accum;
  logic                     w_decide;
  logic [1:0]               r_symbol_out;
  logic                     r_symbol_valid;

  dds u_dds (
    .clk      (clk),
    .reset    (reset),
    .fcw      (fcw),
    .data_sin (w_sin),
    .data_cos (w_cos)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i_prod <= '0;
      r_q_prod <= '0;
    end else begin
      r_i_prod <= PROD_W'((32'(rx_sample) * 32'(w_cos)) >>> 15);
      r_q_prod <= PROD_W'(-((32'(rx_sample) * 32'(w_sin)) >>> 15));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Sync overrides whatever the state would otherwise do, including a pending DUMP.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accum     = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_INTEGRATE;
      ST_INTEGRATE: begin
        w_accum = 1'b1;
        if (r_symbol_cnt == CNT_LAST) w_state_nxt = ST_DUMP;
      end
      ST_DUMP: begin
        w_decide    = 1'b1;
        w_load      = 1'b1;
        w_state_nxt = ST_INTEGRATE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (sym_sync && (r_state != ST_IDLE)) begin
      w_load      = 1'b1;
      w_accum     = 1'b0;
      w_decide    = 1'b0;
      w_state_nxt = ST_INTEGRATE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i_acc        <= '0;
      r_q_acc        <= '0;
      r_symbol_cnt   <= '0;
      r_symbol_out   <= 2'b00;
      r_symbol_valid <= 1'b0;
    end else begin
      r_symbol_valid <= w_decide;
      if (w_decide) r_symbol_out <= sign_to_sym(r_i_acc[ACC_W-1], r_q_acc[ACC_W-1]);
      if (w_load) begin
        r_i_acc      <= ACC_W'(r_i_prod);
        r_q_acc      <= ACC_W'(r_q_prod);
        r_symbol_cnt <= 8'd1;
      end else if (w_accum) begin
        r_i_acc      <= r_i_acc + ACC_W'(r_i_prod);
        r_q_acc      <= r_q_acc + ACC_W'(r_q_prod);
        r_symbol_cnt <= r_symbol_cnt + 8'd1;
      end
    end
  end

  assign symbol_out   = r_symbol_out;
  assign symbol_valid = r_symbol_valid;

`ifdef QPSK_DEMOD_DEBUG_EN
  logic signed [ACC_W-1:0] r_i_acc_dbg;
  logic signed [ACC_W-1:0] r_q_acc_dbg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i_acc_dbg <= '0;
      r_q_acc_dbg <= '0;
    end else if (w_decide) begin
      r_i_acc_dbg <= r_i_acc;
      r_q_acc_dbg <= r_q_acc;
    end
  end

  assign i_acc_out = r_i_acc_dbg;
  assign q_acc_out = r_q_acc_dbg;
`endif

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Scoreboard bench for qpsk_demodulator: loopback, zero input, sync realign,
// mid-symbol reset and full-scale accumulation.
module tb_qpsk_demodulator;
  import qpsk_pkg::*;

  localparam int P         = 100;
  localparam int ACC_NONE  = 0;
  localparam int ACC_EXACT = 1;
  localparam int ACC_SIGN  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qpsk_demodulator_if bus();

  logic               tx_en;
  logic [1:0]         tx_sym;
  logic signed [15:0] rx_const;
  logic signed [15:0] m_sin;
  logic signed [15:0] m_cos;
  logic signed [23:0] obs_i;
  logic signed [23:0] obs_q;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int r0;
  int r1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference modulator sharing the carrier generator and reset with the DUT.
  dds u_ref_dds (
    .clk      (clk),
    .reset    (reset),
    .fcw      (bus.fcw),
    .data_sin (m_sin),
    .data_cos (m_cos)
  );

  assign bus.rx_sample = tx_en ? mod_sample(tx_sym, m_sin, m_cos) : rx_const;

`ifdef QPSK_DEMOD_DEBUG_EN
  logic signed [23:0] dbg_i;
  logic signed [23:0] dbg_q;
  always_comb begin
    obs_i = dbg_i;
    obs_q = dbg_q;
  end
`else
  always @(negedge clk) begin
    if (dut.r_state == ST_DUMP) begin
      obs_i <= dut.r_i_acc;
      obs_q <= dut.r_q_acc;
    end
  end
`endif

  qpsk_demodulator #(
    .SYSTEM_CLK_FREQ (100_000_000),
    .SYMBOL_RATE     (1_000_000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fcw          (bus.fcw),
    .rx_sample    (bus.rx_sample),
    .sym_sync     (bus.sym_sync),
    .symbol_out   (bus.symbol_out),
    .symbol_valid (bus.symbol_valid)
`ifdef QPSK_DEMOD_DEBUG_EN
    ,
    .i_acc_out    (dbg_i),
    .q_acc_out    (dbg_q)
`endif
  );

  typedef struct {
    logic [1:0] sym;
    int         cyc;
    int         acc_mode;
    int         exp_i;
    int         exp_q;
  } exp_t;

  exp_t q_exp[$];
  exp_t e;
  iq_sign_t e_sign;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [1:0] sym, input int c, input int mode,
                      input int ei, input int eq);
    exp_t x;
    x.sym = sym; x.cyc = c; x.acc_mode = mode; x.exp_i = ei; x.exp_q = eq;
    q_exp.push_back(x);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.symbol_valid) begin
      check("valid_single_cycle", prev_valid, 0);
      if (q_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got symbol %b at cycle %0d, expected no decision",
                 bus.symbol_out, cyc);
      end else begin
        e = q_exp.pop_front();
        check("symbol_out", bus.symbol_out, e.sym);
        check("valid_cycle", cyc, e.cyc);
        if (e.acc_mode == ACC_EXACT) begin
          check("i_acc", obs_i, e.exp_i);
          check("q_acc", obs_q, e.exp_q);
        end else if (e.acc_mode == ACC_SIGN) begin
          e_sign = sym_to_sign(e.sym);
          check("i_acc_sign", obs_i < 0, e_sign.i_neg);
          check("q_acc_sign", obs_q < 0, e_sign.q_neg);
        end
      end
    end
    prev_valid <= bus.symbol_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    bus.fcw      = 32'h1000_0000;
    bus.sym_sync = 1'b0;
    tx_en        = 1'b1;
    tx_sym       = 2'b00;
    rx_const     = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", bus.symbol_valid, 0);
    check("reset_symbol", bus.symbol_out, 0);

    // Release mid-cycle: that cycle is IDLE, P integrate cycles follow, then DUMP,
    // so each decision surfaces P+2 edges after the window's release/alignment point.
    r0 = cyc;
    for (int unsigned k = 0; k < 4; k++)
      push(2'(k), r0 + (int'(k) + 1) * P + 2, ACC_SIGN, 0, 0);
    push(2'b00, r0 + 5 * P + 2, ACC_EXACT, 0, 0);
    push(2'b00, r0 + 6 * P + 2, ACC_EXACT, 0, 0);
    // Sync sampled at edge r0+6P+52 restarts the window; decision P edges later.
    push(2'b10, r0 + 7 * P + 52, ACC_SIGN, 0, 0);
    reset = 1'b1;

    for (int unsigned k = 1; k < 4; k++) begin
      wait_until(r0 + int'(k) * P);
      tx_sym = 2'(k);
    end
    wait_until(r0 + 4 * P);
    tx_en = 1'b0;
    wait_until(r0 + 6 * P);
    tx_sym = 2'b10;
    tx_en  = 1'b1;
    wait_until(r0 + 6 * P + 51);
    bus.sym_sync = 1'b1;
    @(negedge clk);
    bus.sym_sync = 1'b0;

    // symbol_cnt is 1 in the valid cycle, so 29 cycles later it reads 30.
    wait_until(r0 + 7 * P + 52 + 29);
    reset    = 1'b0;
    bus.fcw  = '0;
    tx_en    = 1'b0;
    rx_const = 16'h8000;
    #1;
    check("reset_mid_valid", bus.symbol_valid, 0);
    check("reset_mid_symbol", bus.symbol_out, 0);
    repeat (3) @(negedge clk);
    r1 = cyc;
    push(2'b01, r1 + P + 2,     ACC_EXACT, -3276700, 0);
    push(2'b01, r1 + 2 * P + 2, ACC_EXACT, -3276700, 0);
    reset = 1'b1;

    for (int unsigned t = 0; t < 4 * P && q_exp.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", q_exp.size(), 0);
    repeat (P / 2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qpsk_demodulator.md
QPSK_DEMODULATOR -- requirements
Module: qpsk_demodulator

Interface
REQ-001 SHALL have parameter SYSTEM_CLK_FREQ, default 100_000_000, system clock rate in Hz.
REQ-002 SHALL have parameter SYMBOL_RATE, default 1_000_000, symbol rate in Hz.
REQ-003 SHALL have parameter SYMBOL_PERIOD, default SYSTEM_CLK_FREQ/SYMBOL_RATE, clocks per symbol (minimum 4).
REQ-004 SHALL have port clk  input  1  the single system clock, rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port fcw  input  32  carrier frequency control word for the internal dds.
REQ-007 SHALL have port rx_sample  input  16 signed  received baseband-at-carrier sample, one per clock.
REQ-008 SHALL have port sym_sync  input  1  pulse that realigns the symbol window.
REQ-009 SHALL have port symbol_out  output  2  decided symbol, held until the next decision.
REQ-010 SHALL have port symbol_valid  output  1  one-cycle pulse per decision.

Function
REQ-011 SHALL use FSM states IDLE, INTEGRATE and DUMP: IDLE->INTEGRATE unconditionally; INTEGRATE->DUMP when symbol_cnt == SYMBOL_PERIOD-1; DUMP->INTEGRATE unconditionally.
REQ-012 SHALL register the mixer products each clock: i_prod = (rx_sample*dds_cos)>>>15 and q_prod = -((rx_sample*dds_sin)>>>15), with 32-bit signed multiplies and arithmetic shifts.
REQ-013 SHALL accumulate i_prod and q_prod into 24-bit signed accumulators i_acc and q_acc on every INTEGRATE cycle, incrementing symbol_cnt.
REQ-014 In DUMP, SHALL decide from the sign of i_acc and q_acc, treating zero as positive: (I+,Q+)->00, (I-,Q+)->01, (I-,Q-)->10, (I+,Q-)->11.
REQ-015 In DUMP, SHALL load the accumulators with the current products, set symbol_cnt to 1 and pulse symbol_valid, so each window integrates exactly SYMBOL_PERIOD products.
REQ-016 SHALL assert symbol_valid in the cycle after DUMP, with symbol_out updated in the same cycle; symbol_valid SHALL never be high in two consecutive cycles.
REQ-017 If sym_sync is high in any non-IDLE cycle, SHALL load the accumulators with the current products, set symbol_cnt to 1 and enter INTEGRATE without a decision; sym_sync SHALL take priority over DUMP.
REQ-018 SHALL not overflow the accumulators: |product| <= 32768 and SYMBOL_PERIOD <= 255.

Reset
REQ-019 While reset is low, SHALL force state=IDLE, symbol_cnt=0, i_acc=q_acc=0, mixer registers=0, symbol_out=2'b00 and symbol_valid=0.
REQ-020 Reset deassertion mid-symbol SHALL discard the partial window; the first decision SHALL occur SYMBOL_PERIOD+1 cycles after IDLE.

Configuration
REQ-021 With QPSK_DEMOD_DEBUG_EN defined, SHALL add output ports i_acc_out and q_acc_out (24 signed), carrying the accumulator values latched at each DUMP.
REQ-022 Without QPSK_DEMOD_DEBUG_EN, those ports and their registers SHALL be absent, with no other behavioural change.

Structure
REQ-023 SHALL take the FSM state encodings, the symbol-to-(I,Q) sign table, AMP=16000 and the accumulator width from a shared package qpsk_pkg, which the modulator also uses.
REQ-024 SHALL instantiate the existing dds sub-module (clk, reset, fcw, data_sin, data_cos) as its only child.

Verification
REQ-025 Loopback: drive rx_sample from the modulator tx_sample_out with the same fcw and aligned windows, sending symbols 00,01,10,11 -> symbol_out returns 00,01,10,11 in order, one symbol_valid per SYMBOL_PERIOD.
REQ-026 Constant rx_sample=0 -> every decision is 00 and the accumulators stay 0.
REQ-027 sym_sync pulse at symbol_cnt=50 -> no symbol_valid for that window; the next symbol_valid occurs SYMBOL_PERIOD cycles later.
REQ-028 Reset asserted at symbol_cnt=30 -> symbol_valid=0 and symbol_out=00 immediately; the first valid occurs SYMBOL_PERIOD+1 cycles after release.
REQ-029 Full-scale rx_sample=-32768 with fcw set for cos=32767 over a window -> no accumulator wrap (i_acc = -3,276,700 for SYMBOL_PERIOD=100).
REQ-030 With QPSK_DEMOD_DEBUG_EN defined, in the loopback case -> i_acc_out and q_acc_out signs match the transmitted symbol.
